display_scan_driver: RTL and testbench
======================================

# display_scan_driver

Time-multiplexed scan driver for the board's 8-digit common-anode seven-segment display. Generates the per-digit refresh tick, steps the digit index, produces the active-low anode select for that index, and decodes the selected hex nibble into active-low cathodes. Inter-digit blanking prevents ghosting. A load/ready handshake lets upstream logic (Gray decoder, counters) update the displayed value tear-free at frame boundaries.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- REFRESH_HZ, 10_000, digit-slot rate; DIV = CLK_HZ/REFRESH_HZ cycles per slot.
- BLANK_CYCLES, 100, anodes-off cycles at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < DIV.
- NUM_DIGITS, 8, digits scanned; index width = clog2(NUM_DIGITS).

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- valor  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i (digit 0 = units, rightmost).
- puntos  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- habilitar  in  NUM_DIGITS  digit enable, 1 = shown.
- cargar  in  1  load strobe; sampled only when listo = 1.
- listo  out  1  ready; 1 = no load pending.
- anodo  out  NUM_DIGITS  active-low digit select, registered.
- catodo  out  8  active-low {dp,g,f,e,d,c,b,a}, registered.
- digito_actual  out  clog2(NUM_DIGITS)  index of the current slot.
- fin_trama  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler: free-running 0..DIV-1; tick = 1 for the single cycle presc == DIV-1.
- Registers: pending {valor,puntos,habilitar} + pending_valid; active copy used for display.
- Handshake: cargar && listo → capture inputs into pending, pending_valid = 1. listo = ~pending_valid. cargar while listo = 0 ignored (no overwrite).
- FSM states BLANK, SHOW:
  - BLANK: anodo = all 1, catodo = all 1; blank counter counts BLANK_CYCLES cycles, then → SHOW.
  - SHOW: anodo[i] = 0 only for i = digito_actual and active habilitar[i] = 1; catodo = ~{dp, seg(nibble)}. Disabled digit: all anodes high for that slot (slot timing unchanged; digits are never skipped).
  - On tick (either state): digito_actual ← index+1, wrapping NUM_DIGITS-1 → 0; → BLANK; blank counter reset.
- Frame boundary = tick while digito_actual == NUM_DIGITS-1: fin_trama = 1 that cycle; if pending_valid, active ← pending and pending_valid ← 0 (listo high next cycle).
- cargar accepted in the same cycle as a boundary → captured, applied at the next boundary.
- Reset (async, rst_n = 0): anodo = all 1, catodo = all 1, digito_actual = 0, state BLANK, blank counter 0, presc 0, active/pending = 0, pending_valid = 0, listo = 1, fin_trama = 0.
- Hex decode covers 0-F (A,b,C,d,E,F); standard segment patterns.

## Timing
- All outputs registered; anodo/catodo change the cycle after the state transition that causes it.
- After reset release: BLANK_CYCLES cycles dark, then digit 0 shown until first tick at cycle DIV-1.
- Each slot: exactly DIV cycles: BLANK_CYCLES dark + DIV-BLANK_CYCLES lit. Frame = NUM_DIGITS·DIV cycles.
- Load latency: new value visible in digit 0's SHOW phase after the next boundary; worst case ≈ one frame + BLANK_CYCLES + 1.
- Reset asserted mid-slot: outputs go dark immediately (asynchronously); the pending load is discarded.

## Structure
- Shared package: segment pattern constants for 0-F, anode-off constant, FSM state enum.
- Sub-module: hex_a_7seg (4-bit nibble + dp → 8-bit active-low cathode); purely combinational, output registered in the parent.

## Test plan
Bench parameters: CLK_HZ = 1000, REFRESH_HZ = 100 (DIV = 10), BLANK_CYCLES = 2, NUM_DIGITS = 8.
- Reset then load valor = 32'h7654_3210, habilitar = 8'hFF → digit i lit on cycles 2-9 of slot i with anodo = ~(1<<i) and catodo = pattern(i); fin_trama every 80 cycles.
- Nibble F, puntos[3] = 1 in digit 3 → catodo = 8'b0000_1110 during slot 3 only.
- habilitar = 8'b0000_0011 → slots 2-7 keep anodo = 8'hFF for all 10 cycles; slot timing unchanged.
- cargar mid-frame → listo = 0 until the boundary; a second cargar is ignored; digit 0 of the next frame shows the first value.
- cargar coincident with fin_trama → value applied one frame later.
- rst_n low during SHOW of digit 5 → anodo = 8'hFF and catodo = 8'hFF immediately; digito_actual = 0 and listo = 1.

Source files
------------

// File: rtl/display_scan_driver_pkg.sv
// display_scan_driver_pkg: segment patterns, blanking constants and scan FSM states.
package display_scan_driver_pkg;
    // Active-high {g,f,e,d,c,b,a} for hex digits 0-F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [31:0] ANODO_APAGADO  = '1;
    localparam logic [7:0]  CATODO_APAGADO = 8'hFF;

    typedef enum logic {BLANK, SHOW} estado_t;
endpackage

// File: rtl/display_scan_driver_hex_a_7seg.sv
// hex_a_7seg: nibble plus decimal point to active-low {dp,g,f,e,d,c,b,a}.
module hex_a_7seg
    import display_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       punto,
    output logic [7:0] catodo
);
    assign catodo = ~{punto, SEG_HEX[nibble]};
endmodule

// File: rtl/display_scan_driver.sv
// display_scan_driver: multiplexed 7-segment scan with inter-digit blanking
// and a frame-synchronous load handshake for tear-free updates.
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 10_000,
    parameter int BLANK_CYCLES = 100,
    parameter int NUM_DIGITS   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4*NUM_DIGITS-1:0]       valor,
    input  logic [NUM_DIGITS-1:0]         puntos,
    input  logic [NUM_DIGITS-1:0]         habilitar,
    input  logic                          cargar,
    output logic                          listo,
    output logic [NUM_DIGITS-1:0]         anodo,
    output logic [7:0]                    catodo,
    output logic [$clog2(NUM_DIGITS)-1:0] digito_actual,
    output logic                          fin_trama
);
    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int IW  = $clog2(NUM_DIGITS);
    localparam int VW  = 4 * NUM_DIGITS;
    localparam int CW  = VW + 2 * NUM_DIGITS;

    logic [PW-1:0]         presc_q, presc_d, blank_q, blank_d;
    logic [IW-1:0]         digito_q, digito_d;
    estado_t               estado_q, estado_d;
    logic [CW-1:0]         pend_q, pend_d, act_q, act_d;
    logic                  pend_valido_q, pend_valido_d;
    logic [NUM_DIGITS-1:0] anodo_q, anodo_d;
    logic [7:0]            catodo_q, catodo_d, seg;
    logic                  tick, fin;
    logic [VW-1:0]         act_valor;
    logic [NUM_DIGITS-1:0] act_puntos, act_hab;

    assign act_valor  = act_q[CW-1 -: VW];
    assign act_puntos = act_q[2*NUM_DIGITS-1 -: NUM_DIGITS];
    assign act_hab    = act_q[NUM_DIGITS-1:0];

    hex_a_7seg u_hex (
        .nibble (act_valor[{digito_q, 2'b00} +: 4]),
        .punto  (act_puntos[digito_q]),
        .catodo (seg)
    );

    always_comb begin
        tick          = presc_q == PW'(DIV - 1);
        fin           = tick && digito_q == IW'(NUM_DIGITS - 1);
        presc_d       = tick ? '0 : presc_q + 1'b1;
        digito_d      = tick ? (fin ? '0 : digito_q + 1'b1) : digito_q;
        estado_d      = estado_q;
        blank_d       = blank_q;
        pend_d        = pend_q;
        pend_valido_d = pend_valido_q;
        act_d         = act_q;
        if (tick) begin
            estado_d = BLANK;
            blank_d  = '0;
        end else if (estado_q == BLANK) begin
            blank_d  = blank_q + 1'b1;
            estado_d = blank_q == PW'(BLANK_CYCLES - 1) ? SHOW : BLANK;
        end
        // Swap only at the frame boundary so a frame never mixes old and new data.
        if (fin && pend_valido_q) begin
            act_d         = pend_q;
            pend_valido_d = 1'b0;
        end
        if (cargar && !pend_valido_q) begin
            pend_d        = {valor, puntos, habilitar};
            pend_valido_d = 1'b1;
        end
        // Outputs follow the next state so they register in step with it.
        anodo_d  = (estado_d == SHOW && act_hab[digito_q])
                 ? ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << digito_q)
                 : ANODO_APAGADO[NUM_DIGITS-1:0];
        catodo_d = estado_d == SHOW ? seg : CATODO_APAGADO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            blank_q       <= '0;
            digito_q      <= '0;
            estado_q      <= BLANK;
            pend_q        <= '0;
            pend_valido_q <= 1'b0;
            act_q         <= '0;
            anodo_q       <= ANODO_APAGADO[NUM_DIGITS-1:0];
            catodo_q      <= CATODO_APAGADO;
        end else begin
            presc_q       <= presc_d;
            blank_q       <= blank_d;
            digito_q      <= digito_d;
            estado_q      <= estado_d;
            pend_q        <= pend_d;
            pend_valido_q <= pend_valido_d;
            act_q         <= act_d;
            anodo_q       <= anodo_d;
            catodo_q      <= catodo_d;
        end
    end

    assign listo         = ~pend_valido_q;
    assign anodo         = anodo_q;
    assign catodo        = catodo_q;
    assign digito_actual = digito_q;
    assign fin_trama     = fin;
endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver: random and directed scan/load checks against a cycle-arithmetic model.
module tb_display_scan_driver;
    localparam int N = 8, DV = 10, BL = 2, FR = N * DV;
    localparam logic [6:0] SEGM [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        clk = 1'b0, rst_n = 1'b0, cargar = 1'b0;
    logic [31:0] valor = '0;
    logic [7:0]  puntos = '0, habilitar = '0;
    logic        listo, fin_trama;
    logic [7:0]  anodo, catodo;
    logic [2:0]  digito_actual;

    int total = 0, bad = 0, t = 0;
    logic [47:0] act = '0, pend = '0;
    logic        pv = 1'b0;

    always #5 clk = ~clk;

    display_scan_driver #(
        .CLK_HZ(1000), .REFRESH_HZ(100), .BLANK_CYCLES(BL), .NUM_DIGITS(N)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valor(valor), .puntos(puntos),
        .habilitar(habilitar), .cargar(cargar), .listo(listo), .anodo(anodo),
        .catodo(catodo), .digito_actual(digito_actual), .fin_trama(fin_trama)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic check_cycle();
        int p, d;
        logic [31:0] v;
        logic [7:0] dp, hb, ea, ec;
        logic [3:0] nib;
        p   = t % DV;
        d   = (t / DV) % N;
        v   = act[47:16];
        dp  = act[15:8];
        hb  = act[7:0];
        nib = v[4*d +: 4];
        ea  = (p >= BL && hb[d]) ? ~(8'd1 << d) : 8'hFF;
        ec  = (p >= BL) ? ~{dp[d], SEGM[nib]} : 8'hFF;
        chk("anodo", anodo, ea);
        chk("catodo", catodo, ec);
        chk("digito", digito_actual, d);
        chk("fin_trama", fin_trama, p == DV - 1 && d == N - 1);
        chk("listo", listo, !pv);
    endtask

    task automatic step(input logic c, input logic [31:0] v, input logic [7:0] pt, input logic [7:0] hb);
        logic acc;
        cargar = c; valor = v; puntos = pt; habilitar = hb;
        acc = c && !pv;
        @(posedge clk);
        if (t % FR == FR - 1 && pv) begin
            act = pend;
            pv  = 1'b0;
        end
        if (acc) begin
            pend = {v, pt, hb};
            pv   = 1'b1;
        end
        t++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom, 8'($urandom), 8'($urandom));
    endtask

    task automatic to_boundary();
        while (t % FR != FR - 1) idle(1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_cycle();
        rst_n = 1'b1;
        check_cycle();
        step(1'b1, 32'h7654_3210, 8'h00, 8'hFF);
        idle(3 * FR);
        step(1'b1, 32'h7654_F210, 8'h08, 8'hFF);
        idle(2 * FR);
        step(1'b1, 32'h89AB_CDEF, 8'h00, 8'h03);
        idle(2 * FR);
        idle(25);
        step(1'b1, 32'hDEAD_BEEF, 8'h81, 8'hFF);
        idle(10);
        step(1'b1, 32'h1111_1111, 8'hFF, 8'h0F);
        idle(2 * FR);
        to_boundary();
        step(1'b1, 32'hCAFE_0123, 8'h24, 8'hF7);
        idle(3 * FR);
        for (int i = 0; i < 2000; i++)
            step(($urandom % 25 == 0) || (t % FR == FR - 1 && $urandom % 2 == 1),
                 $urandom, 8'($urandom), 8'($urandom));
        step(1'b1, 32'h5555_5555, 8'h00, 8'hFF);
        while (t % FR != 5 * DV + 5) idle(1);
        rst_n = 1'b0;
        #1;
        chk("rst_anodo", anodo, 8'hFF);
        chk("rst_catodo", catodo, 8'hFF);
        chk("rst_digito", digito_actual, 0);
        chk("rst_listo", listo, 1);
        chk("rst_fin", fin_trama, 0);
        act = '0; pend = '0; pv = 1'b0; t = 0;
        @(negedge clk);
        rst_n = 1'b1;
        check_cycle();
        idle(2 * FR);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
